// File: rtl/mem_port_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter_pkg : shared state and access-size encodings        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IBUSY = 2'd1,
    ST_DBUSY = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
// +----------------------------------------------------------------------+
// | mem_arb_starve_ctr : counts DM grants while IF waits; forces IF      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int StarveLimit = 4,
  parameter int CntWidth    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic dm_grant,
  input  logic if_grant,
  output logic force_if
);

  localparam logic [CntWidth-1:0] c_LIMIT = CntWidth'(StarveLimit);

  logic [CntWidth-1:0] r_cnt;

  // An idle fetch port means nobody is being starved, so the count restarts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (if_grant || !if_req) begin
      r_cnt <= '0;
    end else if (dm_grant && (r_cnt < c_LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign force_if = (r_cnt >= c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter : shares one memory port between fetch and data     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int StarveLimit = 4,
  parameter int CntWidth    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  arb_state_t  r_state;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [1:0]  r_mem_size;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_rdata;
  logic        r_if_valid;
  logic        r_dm_valid;
  logic        r_drop;

  logic w_force_if;
  logic w_grant_dm;
  logic w_grant_if;

  assign w_grant_dm = (r_state == ST_IDLE) && dm_req && (!w_force_if || !if_req);
  assign w_grant_if = (r_state == ST_IDLE) && !w_grant_dm && if_req && !if_flush;

  mem_arb_starve_ctr #(
    .StarveLimit (StarveLimit),
    .CntWidth    (CntWidth)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .dm_grant (w_grant_dm),
    .if_grant (w_grant_if),
    .force_if (w_force_if)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_size  <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant_dm) begin
            r_mem_we    <= dm_we;
            r_mem_size  <= dm_size;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            r_mem_req   <= 1'b1;
            r_state     <= ST_DBUSY;
          end else if (w_grant_if) begin
            r_mem_we    <= 1'b0;
            r_mem_size  <= c_SIZE_WORD;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_req   <= 1'b1;
            r_drop      <= 1'b0;
            r_state     <= ST_IBUSY;
          end
        end
        ST_IBUSY, ST_DBUSY: begin
          if ((r_state == ST_IBUSY) && if_flush) begin
            r_drop <= 1'b1;
          end
          if (mem_ack) begin
            r_rdata   <= mem_rdata;
            r_mem_req <= 1'b0;
            r_state   <= ST_RESP;
            // A redirect seen on the ack cycle itself must also kill the fetch.
            if (r_state == ST_IBUSY) begin
              r_if_valid <= !(r_drop || if_flush);
            end else begin
              r_dm_valid <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          r_if_valid <= 1'b0;
          r_dm_valid <= 1'b0;
          r_drop     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_size  = r_mem_size;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // A redirect landing on the response cycle still suppresses the fetch.
  assign if_valid = r_if_valid && !if_flush;
  assign dm_valid = r_dm_valid;
  assign if_rdata = r_rdata;
  assign dm_rdata = r_rdata;

  assign if_stall = if_req && !if_valid;
  assign dm_stall = dm_req && !dm_valid;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter : vector table + scoreboard bench for the arbiter|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  typedef struct {
    logic        is_if;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        chk_data;
  } txn_t;

  typedef struct {
    logic        ifr;
    logic [31:0] if_addr;
    logic        dm;
    logic        dm_we;
    logic [1:0]  dm_size;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    int          wait_cycles;
    logic        noise;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_valid, dm_stall;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int   total = 0;
  int   bad = 0;
  int   mwait = 0;
  int   mcnt = 0;
  int   dm_remaining = 1;
  logic ack_noise = 1'b0;
  txn_t mq[$];
  txn_t rq[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .StarveLimit (4),
    .CntWidth    (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .if_stall  (if_stall),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_size   (dm_size),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_valid  (dm_valid),
    .dm_stall  (dm_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h2001_0005;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic txn_t mk_if(input logic [31:0] a);
    txn_t e;
    e.is_if = 1'b1; e.we = 1'b0; e.size = 2'b10; e.addr = a;
    e.wdata = '0; e.rdata = mem_fn(a); e.chk_data = 1'b1;
    return e;
  endfunction

  function automatic txn_t mk_dm(input logic we, input logic [1:0] sz,
                                 input logic [31:0] a, input logic [31:0] wd);
    txn_t e;
    e.is_if = 1'b0; e.we = we; e.size = sz; e.addr = a;
    e.wdata = wd; e.rdata = mem_fn(a); e.chk_data = !we;
    return e;
  endfunction

  // One clock: check responses, retire requests, then play the memory.
  task automatic tick();
    txn_t e;
    @(negedge clk);
    chk("if_stall", if_stall, if_req & ~if_valid);
    chk("dm_stall", dm_stall, dm_req & ~dm_valid);
    if (if_valid) begin
      if (rq.size() == 0) flag_fail("unexpected_if_valid");
      else begin
        e = rq.pop_front();
        chk("rsp_is_if", 32'(e.is_if), 32'd1);
        if (e.chk_data) chk("if_rdata", if_rdata, e.rdata);
      end
      if_req = 1'b0;
    end
    if (dm_valid) begin
      if (rq.size() == 0) flag_fail("unexpected_dm_valid");
      else begin
        e = rq.pop_front();
        chk("rsp_is_dm", 32'(e.is_if), 32'd0);
        if (e.chk_data) chk("dm_rdata", dm_rdata, e.rdata);
      end
      dm_remaining--;
      if (dm_remaining <= 0) dm_req = 1'b0;
    end
    if (mem_req) begin
      if (mcnt >= mwait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_fn(mem_addr);
        if (mq.size() == 0) flag_fail("unexpected_mem_txn");
        else begin
          e = mq.pop_front();
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_size", 32'(mem_size), 32'(e.size));
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      mcnt++;
    end else begin
      mem_ack   = ack_noise;
      mem_rdata = $urandom;
      mcnt      = 0;
    end
  endtask

  task automatic run_until_done(input int limit);
    logic done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (!if_req && !dm_req && rq.size() == 0 && mq.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk("drain_in_budget", 32'(done), 32'd1);
    tick();
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    mwait     = v.wait_cycles;
    ack_noise = v.noise;
    if (v.dm) begin
      dm_req = 1'b1; dm_we = v.dm_we; dm_size = v.dm_size;
      dm_addr = v.dm_addr; dm_wdata = v.dm_wdata; dm_remaining = 1;
      mq.push_back(mk_dm(v.dm_we, v.dm_size, v.dm_addr, v.dm_wdata));
      rq.push_back(mk_dm(v.dm_we, v.dm_size, v.dm_addr, v.dm_wdata));
    end
    if (v.ifr) begin
      if_req = 1'b1; if_addr = v.if_addr;
      mq.push_back(mk_if(v.if_addr));
      rq.push_back(mk_if(v.if_addr));
    end
    run_until_done(100);
    ack_noise = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 0, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0104, 1'b1, 1'b1, 2'b10, 32'h0000_0400, 32'hDEAD_BEEF, 0, 1'b0};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 2'b01, 32'h0000_0022, 32'h0, 2, 1'b1};
    vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 32'h0000_0033, 32'h0000_00A5, 1, 1'b1};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 3, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0840, 1'b1, 1'b0, 2'b10, 32'h0000_1234, 32'h0, 1, 1'b1};

    reset = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00; dm_addr = '0; dm_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_dm_valid", 32'(dm_valid), 32'd0);
    chk("rst_rdata", if_rdata, 32'd0);
    reset = 1'b1;
    tick();

    // Reset pulled while a load is waiting on a slow memory.
    mwait = 20;
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b10; dm_addr = 32'h0000_0080;
    dm_remaining = 1;
    repeat (3) tick();
    chk("midrst_busy", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_dm_valid", 32'(dm_valid), 32'd0);
    dm_req = 1'b0;
    mwait = 0;
    tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("midrst_idle", 32'(mem_req), 32'd0);

    // Minimum-latency fetch: mem_req in cycle 1, if_valid in cycle 2.
    if_req = 1'b1; if_addr = 32'h0000_0100;
    mq.push_back(mk_if(32'h0000_0100));
    rq.push_back(mk_if(32'h0000_0100));
    tick();
    chk("lat_mem_req_c1", 32'(mem_req), 32'd1);
    chk("lat_if_valid_c1", 32'(if_valid), 32'd0);
    tick();
    chk("lat_if_valid_c2", 32'(if_valid), 32'd1);
    run_until_done(20);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Starvation: four DM grants, then the waiting fetch, then DM again.
    mwait = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b10; dm_addr = 32'h0000_0200;
    dm_remaining = 5;
    if_req = 1'b1; if_addr = 32'h0000_0300;
    for (int i = 0; i < 4; i++) begin
      mq.push_back(mk_dm(1'b0, 2'b10, 32'h0000_0200, 32'h0));
      rq.push_back(mk_dm(1'b0, 2'b10, 32'h0000_0200, 32'h0));
    end
    mq.push_back(mk_if(32'h0000_0300));
    rq.push_back(mk_if(32'h0000_0300));
    mq.push_back(mk_dm(1'b0, 2'b10, 32'h0000_0200, 32'h0));
    rq.push_back(mk_dm(1'b0, 2'b10, 32'h0000_0200, 32'h0));
    run_until_done(100);

    // Redirect while IDLE blocks the fetch grant for that cycle.
    if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h0000_0440;
    tick();
    chk("flush_idle_nogrant", 32'(mem_req), 32'd0);
    if_flush = 1'b0;
    mq.push_back(mk_if(32'h0000_0440));
    rq.push_back(mk_if(32'h0000_0440));
    run_until_done(20);

    // Redirect during a 3-wait fetch: memory completes, no if_valid.
    mwait = 3;
    if_req = 1'b1; if_addr = 32'h0000_0500;
    mq.push_back(mk_if(32'h0000_0500));
    tick();
    chk("flush_busy_c1", 32'(mem_req), 32'd1);
    if_flush = 1'b1; if_req = 1'b0;
    tick();
    chk("flush_busy_c2", 32'(mem_req), 32'd1);
    if_flush = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0600;
    mq.push_back(mk_if(32'h0000_0600));
    rq.push_back(mk_if(32'h0000_0600));
    run_until_done(40);

    // Five-cycle memory latency on a load.
    mwait = 4;
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b10; dm_addr = 32'h0000_07C0;
    dm_wdata = 32'h1111_2222; dm_remaining = 1;
    mq.push_back(mk_dm(1'b0, 2'b10, 32'h0000_07C0, 32'h0));
    rq.push_back(mk_dm(1'b0, 2'b10, 32'h0000_07C0, 32'h0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("slow_mem_req", 32'(mem_req), 32'd1);
      chk("slow_mem_addr", mem_addr, 32'h0000_07C0);
      chk("slow_mem_we", 32'(mem_we), 32'd0);
      chk("slow_dm_stall", 32'(dm_stall), 32'd1);
    end
    tick();
    chk("slow_dm_valid", 32'(dm_valid), 32'd1);
    run_until_done(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
